// File: rtl/serial_to_parallel_stream_pkg.sv
// Shared definitions for the serial-to-parallel stream packer and its bench.
package serial_to_parallel_pkg;

  localparam int DEF_IN_WIDTH  = 1;
  localparam int DEF_N_BEATS   = 8;
  localparam int DEF_LSB_FIRST = 1;

  // Width needed to hold a beat count of 0..n_beats.
  function automatic int cnt_w(input int n_beats);
    return (n_beats < 1) ? 1 : $clog2(n_beats + 1);
  endfunction

endpackage

// File: rtl/serial_to_parallel_stream_if.sv
// Serial beat input channel plus parallel word output channel.
// The master drives beats and accepts words; the slave is the packer.
interface serial_to_parallel_stream_if
  import serial_to_parallel_pkg::*;
#(
  parameter int in_width = DEF_IN_WIDTH,
  parameter int n_beats  = DEF_N_BEATS
) ();

  localparam int out_width = in_width * n_beats;
  localparam int count_w   = cnt_w(n_beats);

  logic                 serial_valid;
  logic                 serial_ready;
  logic [in_width-1:0]  serial_data;
  logic                 serial_last;
  logic                 parallel_valid;
  logic                 parallel_ready;
  logic [out_width-1:0] parallel_data;
  logic [count_w-1:0]   parallel_count;
  logic                 parallel_last;

  modport master (
    output serial_valid, serial_data, serial_last, parallel_ready,
    input  serial_ready, parallel_valid, parallel_data, parallel_count, parallel_last
  );

  modport slave (
    input  serial_valid, serial_data, serial_last, parallel_ready,
    output serial_ready, parallel_valid, parallel_data, parallel_count, parallel_last
  );

endinterface

// File: rtl/serial_to_parallel_stream_accumulator.sv
// Beat accumulator: packs accepted beats into a word, tracks the beat
// counter and detects word completion. A completed word that cannot move
// to the output register is parked here (acc_full) until it can.
module s2p_accumulator
  import serial_to_parallel_pkg::*;
#(
  parameter int in_width  = DEF_IN_WIDTH,
  parameter int n_beats   = DEF_N_BEATS,
  parameter int lsb_first = DEF_LSB_FIRST,
  localparam int OW = in_width * n_beats,
  localparam int CW = cnt_w(n_beats)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_beat,
  input  logic [in_width-1:0] i_data,
  input  logic                i_last,
  input  logic                i_out_take,
  output logic                o_acc_full,
  output logic                o_word_valid,
  output logic [OW-1:0]       o_word_data,
  output logic [CW-1:0]       o_word_count,
  output logic                o_word_last
);

  localparam logic [CW-1:0] LAST_IDX = CW'(n_beats - 1);

  logic [OW-1:0] r_data;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_hold_count;
  logic          r_hold_last;
  logic          r_acc_full;

  logic [CW-1:0] w_slot;
  logic [CW-1:0] w_cnt_inc;
  logic [OW-1:0] w_merged;
  logic          w_complete;

  // Merge the incoming beat into its slice and detect word completion.
  always_comb begin
    w_cnt_inc  = r_cnt + CW'(1);
    w_slot     = (lsb_first != 0) ? r_cnt : (LAST_IDX - r_cnt);
    w_merged   = r_data;
    w_merged[w_slot*in_width +: in_width] = i_data;
    w_complete = i_beat && ((r_cnt == LAST_IDX) || i_last);
  end

  // Offer either the parked word or the word completing this cycle.
  always_comb begin
    o_acc_full   = r_acc_full;
    o_word_valid = r_acc_full || w_complete;
    o_word_data  = r_acc_full ? r_data       : w_merged;
    o_word_count = r_acc_full ? r_hold_count : w_cnt_inc;
    o_word_last  = r_acc_full ? r_hold_last  : i_last;
  end

  // Accumulate beats; park a completed word when the output is busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data       <= '0;
      r_cnt        <= '0;
      r_hold_count <= '0;
      r_hold_last  <= 1'b0;
      r_acc_full   <= 1'b0;
    end else if (r_acc_full) begin
      if (i_out_take) begin
        r_acc_full <= 1'b0;
        r_data     <= '0;
      end
    end else if (i_beat) begin
      if (w_complete) begin
        r_cnt <= '0;
        if (i_out_take) begin
          r_data <= '0;
        end else begin
          r_data       <= w_merged;
          r_acc_full   <= 1'b1;
          r_hold_count <= w_cnt_inc;
          r_hold_last  <= i_last;
        end
      end else begin
        r_cnt  <= w_cnt_inc;
        r_data <= w_merged;
      end
    end
  end

endmodule

// File: rtl/serial_to_parallel_stream.sv
// Serial-to-parallel stream packer: multi-bit beats in, wide words out on a
// valid/ready handshake. Holds one word in the output register and one more
// in the accumulator, so backpressure never drops an accepted beat.
module serial_to_parallel_stream
  import serial_to_parallel_pkg::*;
#(
  parameter int in_width  = DEF_IN_WIDTH,
  parameter int n_beats   = DEF_N_BEATS,
  parameter int lsb_first = DEF_LSB_FIRST,
  localparam int OW = in_width * n_beats,
  localparam int CW = cnt_w(n_beats)
) (
  input  logic                          clk,
  input  logic                          rst,
  serial_to_parallel_stream_if.slave    bus
);

  logic          w_acc_full;
  logic          w_word_valid;
  logic [OW-1:0] w_word_data;
  logic [CW-1:0] w_word_count;
  logic          w_word_last;
  logic          w_beat;
  logic          w_out_take;

  logic          r_out_valid;
  logic [OW-1:0] r_out_data;
  logic [CW-1:0] r_out_count;
  logic          r_out_last;

  // serial_ready depends only on registered state, never on parallel_ready.
  assign w_beat     = bus.serial_valid && !w_acc_full;
  assign w_out_take = !r_out_valid || bus.parallel_ready;

  s2p_accumulator #(
    .in_width  (in_width),
    .n_beats   (n_beats),
    .lsb_first (lsb_first)
  ) u_acc (
    .clk          (clk),
    .rst          (rst),
    .i_beat       (w_beat),
    .i_data       (bus.serial_data),
    .i_last       (bus.serial_last),
    .i_out_take   (w_out_take),
    .o_acc_full   (w_acc_full),
    .o_word_valid (w_word_valid),
    .o_word_data  (w_word_data),
    .o_word_count (w_word_count),
    .o_word_last  (w_word_last)
  );

  // Output register: load a word when free or being consumed, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_last  <= 1'b0;
    end else if (w_word_valid && w_out_take) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_word_data;
      r_out_count <= w_word_count;
      r_out_last  <= w_word_last;
    end else if (bus.parallel_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.serial_ready   = !w_acc_full;
  assign bus.parallel_valid = r_out_valid;
  assign bus.parallel_data  = r_out_data;
  assign bus.parallel_count = r_out_count;
  assign bus.parallel_last  = r_out_last;

endmodule

// File: tb/tb_serial_to_parallel_stream.sv
// Bench for serial_to_parallel_stream: directed scenarios on four
// configurations plus a randomized run against a queue-based word model.
module tb_serial_to_parallel_stream;
  import serial_to_parallel_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  serial_to_parallel_stream_if #(.in_width(1), .n_beats(8)) ifa ();
  serial_to_parallel_stream_if #(.in_width(4), .n_beats(2)) ifb ();
  serial_to_parallel_stream_if #(.in_width(4), .n_beats(4)) ifc ();
  serial_to_parallel_stream_if #(.in_width(2), .n_beats(1)) ifd ();

  serial_to_parallel_stream #(.in_width(1), .n_beats(8), .lsb_first(1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  serial_to_parallel_stream #(.in_width(4), .n_beats(2), .lsb_first(0))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  serial_to_parallel_stream #(.in_width(4), .n_beats(4), .lsb_first(1))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));
  serial_to_parallel_stream #(.in_width(2), .n_beats(1), .lsb_first(1))
    dut_d (.clk(clk), .rst(rst), .bus(ifd));

  typedef struct {
    logic [15:0] data;
    int          count;
    bit          last;
  } word_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ifa.serial_valid = 0; ifa.serial_data = '0; ifa.serial_last = 0; ifa.parallel_ready = 0;
    ifb.serial_valid = 0; ifb.serial_data = '0; ifb.serial_last = 0; ifb.parallel_ready = 0;
    ifc.serial_valid = 0; ifc.serial_data = '0; ifc.serial_last = 0; ifc.parallel_ready = 0;
    ifd.serial_valid = 0; ifd.serial_data = '0; ifd.serial_last = 0; ifd.parallel_ready = 0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] got_a;
    logic [21:0] got_c;
    do_reset();
    got_a = {ifa.parallel_valid, ifa.parallel_last, ifa.parallel_count, ifa.parallel_data, ifa.serial_ready};
    tests_run++;
    if (got_a !== {1'b0, 1'b0, 4'd0, 8'h00, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_a: got %h expected %h", got_a, {1'b0, 1'b0, 4'd0, 8'h00, 1'b1});
    end
    got_c = {ifc.parallel_valid, ifc.parallel_last, ifc.parallel_count, ifc.parallel_data, ifc.serial_ready};
    tests_run++;
    if (got_c !== {1'b0, 1'b0, 3'd0, 16'h0000, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_c: got %h expected %h", got_c, {1'b0, 1'b0, 3'd0, 16'h0000, 1'b1});
    end
    tests_run++;
    if ({ifb.parallel_valid, ifb.serial_ready, ifd.parallel_valid, ifd.serial_ready} !== 4'b0101) begin
      tests_failed++;
      $display("FAIL reset_bd: got %b expected 0101",
               {ifb.parallel_valid, ifb.serial_ready, ifd.parallel_valid, ifd.serial_ready});
    end
  endtask

  task automatic test_lsb_first_full();
    logic [7:0]  pat;
    logic [12:0] got;
    pat = 8'h0D;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      ifa.serial_valid = 1'b1;
      ifa.serial_data  = pat[k];
      tick();
      if (k == 6) begin
        tests_run++;
        if (ifa.parallel_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL lsb8_early_valid: got %b expected 0", ifa.parallel_valid);
        end
      end
    end
    ifa.serial_valid = 1'b0;
    got = {ifa.parallel_valid, ifa.parallel_data, ifa.parallel_count};
    tests_run++;
    if ({got, ifa.parallel_last} !== {1'b1, 8'h0D, 4'd8, 1'b0}) begin
      tests_failed++;
      $display("FAIL lsb8_word: got %h expected %h", {got, ifa.parallel_last}, {1'b1, 8'h0D, 4'd8, 1'b0});
    end
    ifa.parallel_ready = 1'b1;
    tick();
    ifa.parallel_ready = 1'b0;
    tests_run++;
    if (ifa.parallel_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL lsb8_consumed: got %b expected 0", ifa.parallel_valid);
    end
  endtask

  task automatic test_msb_first();
    logic [3:0]  beats [2];
    logic [11:0] got;
    beats[0] = 4'hA;
    beats[1] = 4'h5;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      ifb.serial_valid = 1'b1;
      ifb.serial_data  = beats[k];
      tick();
    end
    ifb.serial_valid = 1'b0;
    got = {ifb.parallel_valid, ifb.parallel_data, ifb.parallel_count, ifb.parallel_last};
    tests_run++;
    if (got !== {1'b1, 8'hA5, 2'd2, 1'b0}) begin
      tests_failed++;
      $display("FAIL msb_word: got %h expected %h", got, {1'b1, 8'hA5, 2'd2, 1'b0});
    end
    ifb.parallel_ready = 1'b1;
    tick();
    ifb.parallel_ready = 1'b0;
  endtask

  task automatic test_early_last();
    logic [20:0] got;
    do_reset();
    ifc.serial_valid = 1'b1; ifc.serial_data = 4'h3; ifc.serial_last = 1'b0;
    tick();
    ifc.serial_data = 4'h7; ifc.serial_last = 1'b1;
    tick();
    ifc.serial_valid = 1'b0; ifc.serial_last = 1'b0;
    got = {ifc.parallel_valid, ifc.parallel_data, ifc.parallel_count, ifc.parallel_last};
    tests_run++;
    if (got !== {1'b1, 16'h0073, 3'd2, 1'b1}) begin
      tests_failed++;
      $display("FAIL early_last_word: got %h expected %h", got, {1'b1, 16'h0073, 3'd2, 1'b1});
    end
    // consume and complete a one-beat word on the same edge
    ifc.parallel_ready = 1'b1;
    ifc.serial_valid = 1'b1; ifc.serial_data = 4'h1; ifc.serial_last = 1'b1;
    tick();
    ifc.serial_valid = 1'b0; ifc.serial_last = 1'b0;
    got = {ifc.parallel_valid, ifc.parallel_data, ifc.parallel_count, ifc.parallel_last};
    tests_run++;
    if (got !== {1'b1, 16'h0001, 3'd1, 1'b1}) begin
      tests_failed++;
      $display("FAIL early_last_next: got %h expected %h", got, {1'b1, 16'h0001, 3'd1, 1'b1});
    end
    tick();
    ifc.parallel_ready = 1'b0;
    tests_run++;
    if (ifc.parallel_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL early_last_drain: got %b expected 0", ifc.parallel_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  w1, w2;
    bit          ready_dropped;
    bit          unstable;
    logic [13:0] got;
    w1 = 8'hB4;
    w2 = 8'h3C;
    ready_dropped = 0;
    unstable = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (ifa.serial_ready !== 1'b1) ready_dropped = 1;
      ifa.serial_valid = 1'b1;
      ifa.serial_data  = (i < 8) ? w1[i] : w2[i-8];
      tick();
    end
    tests_run++;
    if (ready_dropped) begin
      tests_failed++;
      $display("FAIL bp_accept16: got serial_ready low expected high during 16 beats");
    end
    got = {ifa.serial_ready, ifa.parallel_valid, ifa.parallel_data, ifa.parallel_count};
    tests_run++;
    if (got !== {1'b0, 1'b1, w1, 4'd8}) begin
      tests_failed++;
      $display("FAIL bp_full: got %h expected %h", got, {1'b0, 1'b1, w1, 4'd8});
    end
    ifa.serial_data = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if ({ifa.serial_ready, ifa.parallel_valid, ifa.parallel_data, ifa.parallel_count, ifa.parallel_last}
          !== {1'b0, 1'b1, w1, 4'd8, 1'b0}) unstable = 1;
    end
    tests_run++;
    if (unstable) begin
      tests_failed++;
      $display("FAIL bp_stable: got output change expected word %h held", w1);
    end
    ifa.serial_valid = 1'b0;
    ifa.parallel_ready = 1'b1;
    tick();
    ifa.parallel_ready = 1'b0;
    got = {ifa.serial_ready, ifa.parallel_valid, ifa.parallel_data, ifa.parallel_count};
    tests_run++;
    if (got !== {1'b1, 1'b1, w2, 4'd8}) begin
      tests_failed++;
      $display("FAIL bp_release: got %h expected %h", got, {1'b1, 1'b1, w2, 4'd8});
    end
    ifa.parallel_ready = 1'b1;
    tick();
    ifa.parallel_ready = 1'b0;
    tests_run++;
    if (ifa.parallel_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_drain: got %b expected 0", ifa.parallel_valid);
    end
  endtask

  task automatic test_reset_midword();
    logic [7:0]  pat;
    int          early_valid;
    logic [12:0] got;
    pat = 8'h96;
    early_valid = 0;
    do_reset();
    ifa.parallel_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ifa.serial_valid = 1'b1;
      ifa.serial_data  = 1'b1;
      tick();
    end
    ifa.serial_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (ifa.parallel_valid !== 1'b0) early_valid++;
    for (int k = 0; k < 8; k++) begin
      ifa.serial_valid = 1'b1;
      ifa.serial_data  = pat[k];
      tick();
      if (k < 7 && ifa.parallel_valid !== 1'b0) early_valid++;
    end
    ifa.serial_valid = 1'b0;
    tests_run++;
    if (early_valid != 0) begin
      tests_failed++;
      $display("FAIL rst_mid_early: got %0d valid cycles expected 0", early_valid);
    end
    got = {ifa.parallel_valid, ifa.parallel_data, ifa.parallel_count};
    tests_run++;
    if (got !== {1'b1, pat, 4'd8}) begin
      tests_failed++;
      $display("FAIL rst_mid_word: got %h expected %h", got, {1'b1, pat, 4'd8});
    end
    tick();
    ifa.parallel_ready = 1'b0;
  endtask

  task automatic test_single_beat();
    logic [1:0] d [4];
    bit         l [4];
    logic [5:0] got;
    d[0] = 2'd1; d[1] = 2'd2; d[2] = 2'd3; d[3] = 2'd0;
    l[0] = 0;    l[1] = 1;    l[2] = 0;    l[3] = 0;
    do_reset();
    ifd.parallel_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ifd.serial_valid = 1'b1;
      ifd.serial_data  = d[k];
      ifd.serial_last  = l[k];
      tick();
      got = {ifd.serial_ready, ifd.parallel_valid, ifd.parallel_data, ifd.parallel_count, ifd.parallel_last};
      tests_run++;
      if (got !== {1'b1, 1'b1, d[k], 1'b1, l[k]}) begin
        tests_failed++;
        $display("FAIL n1_beat%0d: got %b expected %b", k, got, {1'b1, 1'b1, d[k], 1'b1, l[k]});
      end
    end
    ifd.serial_valid = 1'b0;
    ifd.serial_last  = 1'b0;
    tick();
    ifd.parallel_ready = 1'b0;
  endtask

  task automatic test_random();
    word_t       exp_q[$];
    word_t       w;
    logic [15:0] part_data;
    int          part_cnt, accepted, sum_counts, cyc, mode;
    bit          closing, hold_chk;
    logic [20:0] hold_val;
    part_data = '0;
    part_cnt = 0; accepted = 0; sum_counts = 0; cyc = 0;
    closing = 0;
    do_reset();
    while (cyc < 8000) begin
      if (accepted >= 800) closing = 1;
      if (closing && part_cnt == 0 && exp_q.size() == 0 && ifc.parallel_valid === 1'b0) break;
      mode = (cyc / 64) % 3;
      if (closing) begin
        ifc.serial_valid   = (part_cnt != 0);
        ifc.serial_data    = 4'($urandom);
        ifc.serial_last    = 1'b1;
        ifc.parallel_ready = 1'b1;
      end else begin
        ifc.serial_valid   = ($urandom_range(0, 3) != 0);
        ifc.serial_data    = 4'($urandom);
        ifc.serial_last    = ($urandom_range(0, 6) == 0);
        ifc.parallel_ready = (mode == 0) ? 1'b1 :
                             (mode == 1) ? ($urandom_range(0, 1) == 0) :
                                           ($urandom_range(0, 7) == 0);
      end
      if (ifc.parallel_valid && ifc.parallel_ready) begin
        sum_counts += int'(ifc.parallel_count);
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL rand_extra_word: got data %h expected no word", ifc.parallel_data);
        end else begin
          w = exp_q.pop_front();
          if (ifc.parallel_data !== w.data) begin
            tests_failed++;
            $display("FAIL rand_data: got %h expected %h", ifc.parallel_data, w.data);
          end
          tests_run++;
          if (int'(ifc.parallel_count) != w.count || ifc.parallel_last !== w.last) begin
            tests_failed++;
            $display("FAIL rand_count_last: got %0d/%b expected %0d/%b",
                     ifc.parallel_count, ifc.parallel_last, w.count, w.last);
          end
        end
      end
      if (ifc.serial_valid && ifc.serial_ready) begin
        part_data = part_data | (16'(ifc.serial_data) << (4 * part_cnt));
        part_cnt++;
        accepted++;
        if (part_cnt == 4 || ifc.serial_last) begin
          w.data = part_data; w.count = part_cnt; w.last = ifc.serial_last;
          exp_q.push_back(w);
          part_data = '0;
          part_cnt = 0;
        end
      end
      hold_chk = ifc.parallel_valid && !ifc.parallel_ready;
      hold_val = {ifc.parallel_data, ifc.parallel_count, ifc.parallel_last, ifc.parallel_valid};
      tick();
      cyc++;
      if (hold_chk) begin
        tests_run++;
        if ({ifc.parallel_data, ifc.parallel_count, ifc.parallel_last, ifc.parallel_valid} !== hold_val) begin
          tests_failed++;
          $display("FAIL rand_stable: got %h expected %h",
                   {ifc.parallel_data, ifc.parallel_count, ifc.parallel_last, ifc.parallel_valid}, hold_val);
        end
      end
    end
    idle_all();
    tests_run++;
    if (cyc >= 8000) begin
      tests_failed++;
      $display("FAIL rand_timeout: got %0d accepted, %0d words pending expected drain", accepted, exp_q.size());
    end
    tests_run++;
    if (sum_counts != accepted || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rand_beat_total: got %0d counted expected %0d accepted (%0d words left)",
               sum_counts, accepted, exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_lsb_first_full();
    test_msb_first();
    test_early_last();
    test_backpressure();
    test_reset_midword();
    test_single_beat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
